// File: rtl/stream_transpose_pkg.sv
// Shared definitions for the streaming matrix transposer: bank occupancy
// encoding and counter sizing.
package stream_transpose_pkg;

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

  // Index width for a counter spanning 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_transpose_bank.sv
// One M x N matrix bank: a whole row is written per cycle and a whole
// column is read out combinationally.
module transpose_bank
  import stream_transpose_pkg::*;
#(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ROW_W      = cnt_width(ROWS),
  parameter int COL_W      = cnt_width(COLS)
) (
  input  logic                       clk,
  input  logic                       we_i,
  input  logic [ROW_W-1:0]           wr_row_i,
  input  logic [COLS*DATA_WIDTH-1:0] wr_data_i,
  input  logic [COL_W-1:0]           rd_col_i,
  output logic [ROWS*DATA_WIDTH-1:0] rd_data_o
);

  logic [COLS*DATA_WIDTH-1:0] mem_q [ROWS];

  // NOTE: storage has no reset; validity is tracked by the bank state in the
  // parent, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[wr_row_i] <= wr_data_i;
  end

  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < ROWS; i++) begin
      rd_data_o[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i][rd_col_i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/stream_transpose.sv
// Ping-pong streaming transposer: rows of an M x N matrix fill one bank
// while columns of the previous matrix drain from the other.
module stream_transpose
  import stream_transpose_pkg::*;
#(
  parameter int INPUT_SIZE_1 = 8,
  parameter int INPUT_SIZE_2 = 8,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [INPUT_SIZE_2*DATA_WIDTH-1:0] in_row,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [INPUT_SIZE_1*DATA_WIDTH-1:0] out_col,
  output logic                               out_last
);

  localparam int OUTPUT_SIZE_1 = INPUT_SIZE_2;
  localparam int OUTPUT_SIZE_2 = INPUT_SIZE_1;
  localparam int OUT_W = OUTPUT_SIZE_2 * DATA_WIDTH;
  localparam int WR_W  = cnt_width(INPUT_SIZE_1);
  localparam int RD_W  = cnt_width(OUTPUT_SIZE_1);
  localparam logic [WR_W-1:0] WR_LAST = WR_W'(INPUT_SIZE_1 - 1);
  localparam logic [RD_W-1:0] RD_LAST = RD_W'(OUTPUT_SIZE_1 - 1);

  bank_state_e     bank_q [2];
  bank_state_e     bank_d [2];
  logic            wr_sel_q, wr_sel_d;
  logic            rd_sel_q, rd_sel_d;
  logic [WR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [RD_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [OUT_W-1:0] bank_rd [2];
  logic            in_fire, out_fire;

  // Handshake outputs depend on registered bank state only.
  assign in_ready  = (bank_q[wr_sel_q] == BANK_EMPTY);
  assign out_valid = (bank_q[rd_sel_q] == BANK_FULL);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_col   = bank_rd[rd_sel_q];
  assign out_last  = out_valid && (rd_cnt_q == RD_LAST);

  // NOTE: every next-state signal takes its held value first so that no
  // path through this block can infer a latch.
  always_comb begin
    bank_d   = bank_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    // Fill and drain always target different banks, so both may land together.
    if (in_fire) begin
      if (wr_cnt_q == WR_LAST) begin
        bank_d[wr_sel_q] = BANK_FULL;
        wr_cnt_d         = '0;
        wr_sel_d         = ~wr_sel_q;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end
    if (out_fire) begin
      if (rd_cnt_q == RD_LAST) begin
        bank_d[rd_sel_q] = BANK_EMPTY;
        rd_cnt_d         = '0;
        rd_sel_d         = ~rd_sel_q;
      end else begin
        rd_cnt_d = rd_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q   <= '{BANK_EMPTY, BANK_EMPTY};
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      bank_q   <= bank_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    transpose_bank #(
      .ROWS      (INPUT_SIZE_1),
      .COLS      (OUTPUT_SIZE_1),
      .DATA_WIDTH(DATA_WIDTH),
      .ROW_W     (WR_W),
      .COL_W     (RD_W)
    ) u_bank (
      .clk      (clk),
      .we_i     (in_fire && (wr_sel_q == 1'(b))),
      .wr_row_i (wr_cnt_q),
      .wr_data_i(in_row),
      .rd_col_i (rd_cnt_q),
      .rd_data_o(bank_rd[b])
    );
  end

endmodule

// File: tb/tb_stream_transpose.sv
// Directed bench for stream_transpose across five matrix shapes.
module tb_stream_transpose;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  // a: 2x3, b: 2x2, c: 3x3, d: 1x4, e: 4x1 (M x N), all 8-bit elements
  logic a_iv = 0, a_ir, a_ov, a_or = 0, a_ol;  logic [23:0] a_row = '0; logic [15:0] a_col;
  logic b_iv = 0, b_ir, b_ov, b_or = 0, b_ol;  logic [15:0] b_row = '0; logic [15:0] b_col;
  logic c_iv = 0, c_ir, c_ov, c_or = 0, c_ol;  logic [23:0] c_row = '0; logic [23:0] c_col;
  logic d_iv = 0, d_ir, d_ov, d_or = 0, d_ol;  logic [31:0] d_row = '0; logic [7:0]  d_col;
  logic e_iv = 0, e_ir, e_ov, e_or = 0, e_ol;  logic [7:0]  e_row = '0; logic [31:0] e_col;

  stream_transpose #(.INPUT_SIZE_1(2), .INPUT_SIZE_2(3), .DATA_WIDTH(8)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .in_row(a_row),
    .out_valid(a_ov), .out_ready(a_or), .out_col(a_col), .out_last(a_ol));
  stream_transpose #(.INPUT_SIZE_1(2), .INPUT_SIZE_2(2), .DATA_WIDTH(8)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .in_row(b_row),
    .out_valid(b_ov), .out_ready(b_or), .out_col(b_col), .out_last(b_ol));
  stream_transpose #(.INPUT_SIZE_1(3), .INPUT_SIZE_2(3), .DATA_WIDTH(8)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir), .in_row(c_row),
    .out_valid(c_ov), .out_ready(c_or), .out_col(c_col), .out_last(c_ol));
  stream_transpose #(.INPUT_SIZE_1(1), .INPUT_SIZE_2(4), .DATA_WIDTH(8)) u_d (
    .clk(clk), .rst_n(rst_n), .in_valid(d_iv), .in_ready(d_ir), .in_row(d_row),
    .out_valid(d_ov), .out_ready(d_or), .out_col(d_col), .out_last(d_ol));
  stream_transpose #(.INPUT_SIZE_1(4), .INPUT_SIZE_2(1), .DATA_WIDTH(8)) u_e (
    .clk(clk), .rst_n(rst_n), .in_valid(e_iv), .in_ready(e_ir), .in_row(e_row),
    .out_valid(e_ov), .out_ready(e_or), .out_col(e_col), .out_last(e_ol));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] b_rows [6] = '{16'h0201, 16'h0403, 16'h0605, 16'h0807, 16'h0a09, 16'h0c0b};
  logic [15:0] b_cols [6] = '{16'h0301, 16'h0402, 16'h0705, 16'h0806, 16'h0b09, 16'h0c0a};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_a_ir", a_ir, 1);
    check("rst_a_ov", a_ov, 0);
    check("rst_a_ol", a_ol, 0);
    check("rst_d_ov", d_ov, 0);
    step();
    rst_n = 1'b1;
    check("rel_b_ir", b_ir, 1);
    check("rel_e_ov", e_ov, 0);

    // 2x3 basic transpose and one-cycle latency
    a_iv = 1; a_row = 24'h030201;
    check("a_ir0", a_ir, 1);
    step();
    check("a_ov_mid", a_ov, 0);
    a_row = 24'h060504;
    step();
    a_iv = 0;
    check("a_ov_rise", a_ov, 1);
    check("a_col0", a_col, 16'h0401);
    check("a_last0", a_ol, 0);
    a_or = 1;
    step();
    check("a_col1", a_col, 16'h0502);
    check("a_last1", a_ol, 0);
    step();
    check("a_col2", a_col, 16'h0603);
    check("a_last2", a_ol, 1);
    step();
    check("a_ov_done", a_ov, 0);
    a_or = 0;

    // 2x3 with stalled consumer while the next matrix fills the other bank
    a_iv = 1; a_row = 24'h030201;
    step();
    a_row = 24'h060504;
    step();
    check("a_stall_ov", a_ov, 1);
    check("a_stall_c1", a_col, 16'h0401);
    check("a_stall_r1", a_ir, 1);
    a_row = 24'h090807;
    step();
    check("a_stall_c2", a_col, 16'h0401);
    check("a_stall_r2", a_ir, 1);
    a_row = 24'h0c0b0a;
    step();
    a_iv = 0;
    check("a_stall_c3", a_col, 16'h0401);
    check("a_both_full", a_ir, 0);
    check("a_stall_ov3", a_ov, 1);
    step();
    check("a_stall_c4", a_col, 16'h0401);
    check("a_stall_r4", a_ir, 0);
    step();
    check("a_stall_c5", a_col, 16'h0401);
    a_or = 1;
    step();
    check("a_m1_c1", a_col, 16'h0502);
    step();
    check("a_m1_c2", a_col, 16'h0603);
    check("a_m1_last", a_ol, 1);
    step();
    check("a_m2_ov", a_ov, 1);
    check("a_m2_c0", a_col, 16'h0a07);
    check("a_m2_l0", a_ol, 0);
    check("a_reopen", a_ir, 1);
    step();
    check("a_m2_c1", a_col, 16'h0b08);
    step();
    check("a_m2_c2", a_col, 16'h0c09);
    check("a_m2_last", a_ol, 1);
    step();
    check("a_m2_done", a_ov, 0);
    a_or = 0;

    // 2x2 three back-to-back matrices at full rate
    b_or = 1; b_iv = 1;
    for (int k = 0; k < 8; k++) begin
      if (k < 6) begin
        b_row = b_rows[k];
        check("b_ir", b_ir, 1);
      end else begin
        b_iv = 0;
      end
      step();
      if (k == 0) check("b_ov0", b_ov, 0);
      if (k >= 1 && k < 7) begin
        check("b_ov", b_ov, 1);
        check("b_col", b_col, b_cols[k-1]);
        check("b_last", b_ol, 64'((k - 1) % 2));
      end
    end
    check("b_done", b_ov, 0);
    b_or = 0;

    // 3x3 reset after one row discards the partial matrix
    c_iv = 1; c_row = 24'h030201;
    step();
    c_iv = 0;
    rst_n = 1'b0;
    #2;
    check("c_rst_ir", c_ir, 1);
    check("c_rst_ov", c_ov, 0);
    step();
    rst_n = 1'b1;
    c_or = 1; c_iv = 1; c_row = 24'h131211;
    step();
    c_row = 24'h232221;
    step();
    check("c_no_stale", c_ov, 0);
    c_row = 24'h333231;
    step();
    c_iv = 0;
    check("c_ov", c_ov, 1);
    check("c_col0", c_col, 24'h312111);
    check("c_last0", c_ol, 0);
    step();
    check("c_col1", c_col, 24'h322212);
    step();
    check("c_col2", c_col, 24'h332313);
    check("c_last2", c_ol, 1);
    step();
    check("c_done", c_ov, 0);
    c_or = 0;

    // 1x4: every row completes a matrix; extreme byte values pass unchanged
    d_iv = 1; d_row = 32'h017fff80;
    step();
    check("d_ov", d_ov, 1);
    check("d_c0", d_col, 8'h80);
    check("d_l0", d_ol, 0);
    check("d_ir1", d_ir, 1);
    d_row = 32'hfffe8100;
    step();
    d_iv = 0;
    check("d_full_ir", d_ir, 0);
    check("d_hold", d_col, 8'h80);
    d_or = 1;
    step();
    check("d_c1", d_col, 8'hff);
    step();
    check("d_c2", d_col, 8'h7f);
    step();
    check("d_c3", d_col, 8'h01);
    check("d_l3", d_ol, 1);
    step();
    check("d_m2_c0", d_col, 8'h00);
    check("d_m2_ir", d_ir, 1);
    step();
    check("d_m2_c1", d_col, 8'h81);
    step();
    check("d_m2_c2", d_col, 8'hfe);
    step();
    check("d_m2_c3", d_col, 8'hff);
    check("d_m2_l3", d_ol, 1);
    step();
    check("d_done", d_ov, 0);
    d_or = 0;

    // 4x1: a single column per matrix, drained by one handshake
    e_or = 1; e_iv = 1; e_row = 8'h80;
    step();
    e_row = 8'hff;
    step();
    e_row = 8'h01;
    step();
    check("e_ov_mid", e_ov, 0);
    e_row = 8'h7f;
    step();
    e_iv = 0;
    check("e_ov", e_ov, 1);
    check("e_col", e_col, 32'h7f01ff80);
    check("e_last", e_ol, 1);
    step();
    check("e_done", e_ov, 0);
    check("e_ir", e_ir, 1);
    e_or = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
